// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops bytes from the upstream FIFO and sends each as an LSB-first UART frame
// (start bit, 8 data bits, StopBits stop bits) on a registered tx line.
module uart_tx_serializer #(
  parameter int ClksPerBit = 104,
  parameter int StopBits   = 1
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       tx_enable,
  input  logic [7:0] data,
  input  logic       have_next,
  output logic       next,
  output logic       tx,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  localparam int CW = $clog2(StopBits * ClksPerBit);
  localparam logic [CW-1:0] BIT_LAST  = CW'(ClksPerBit - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(StopBits * ClksPerBit - 1);
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          start;
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end
  assign start = state_q == IDLE && tx_enable && have_next;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = START;
          shift_d = data;
        end
      end
      START: if (cnt_q == BIT_LAST) begin
        state_d = DATA;
        cnt_d   = '0;
        bit_d   = '0;
      end
      DATA: if (cnt_q == BIT_LAST) begin
        cnt_d   = '0;
        shift_d = {1'b0, shift_q[7:1]};
        bit_d   = bit_q + 1'b1;
        if (bit_q == 3'd7) state_d = STOP;
      end
      STOP: if (cnt_q == STOP_LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  // tx is registered from the next state so the line changes on the clock edge only
  always_comb begin
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
    next = reset_ni && start;
    busy = state_q != IDLE;
    tx   = tx_q;
  end
endmodule
